// File: rtl/chrono_lap_timer_if.sv
// Board-side bundle for the lap timer: button levels and preset in, segments and status out.
// No valid/ready handshake: inputs are raw asynchronous levels, outputs are registered status.
interface chrono_lap_timer_if;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic       mode_down;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic [6:0] seg0;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic [6:0] seg3;
  logic [6:0] seg4;
  logic [6:0] seg5;
  logic       running;
  logic       done;
  logic       wrap;
  logic       lap_active;
  logic [1:0] state_dbg;

  modport master (
    output start_stop, lap, clear, mode_down, preset_min, preset_sec,
    input  seg0, seg1, seg2, seg3, seg4, seg5,
    input  running, done, wrap, lap_active, state_dbg
  );

  modport slave (
    input  start_stop, lap, clear, mode_down, preset_min, preset_sec,
    output seg0, seg1, seg2, seg3, seg4, seg5,
    output running, done, wrap, lap_active, state_dbg
  );
endinterface

// File: rtl/chrono_lap_timer.sv
// MM:SS.cc BCD stopwatch / countdown with start-pause-clear control, lap freeze and
// registered 7-segment outputs. state_dbg: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.
module chrono_lap_timer #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TICK_HZ        = 100,
  parameter int MAX_MIN        = 59,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic               clk,
  input logic               rst,
  chrono_lap_timer_if.slave bus
);

  localparam int             DIV    = CLK_HZ / TICK_HZ;
  localparam int             PW     = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PMAX   = PW'(DIV - 1);
  localparam logic [3:0]     MAX_M1 = 4'(MAX_MIN / 10);
  localparam logic [3:0]     MAX_M0 = 4'(MAX_MIN % 10);
  localparam logic [6:0]     SEG_ZERO = (SEG_ACTIVE_LOW != 0) ? 7'b1000000 : 7'b0111111;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b0111111;
      4'd1:    r = 7'b0000110;
      4'd2:    r = 7'b1011011;
      4'd3:    r = 7'b1001111;
      4'd4:    r = 7'b1100110;
      4'd5:    r = 7'b1101101;
      4'd6:    r = 7'b1111101;
      4'd7:    r = 7'b0000111;
      4'd8:    r = 7'b1111111;
      4'd9:    r = 7'b1101111;
      default: r = 7'b0000000;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? ~r : r;
  endfunction

  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  // Bit 0 start_stop, bit 1 lap, bit 2 clear.
  logic [2:0] sync1, sync2, sync2_d, edge_q;
  logic       start_e, lap_e, clear_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      sync2_d <= '0;
      edge_q  <= '0;
    end else begin
      sync1   <= {bus.clear, bus.lap, bus.start_stop};
      sync2   <= sync1;
      sync2_d <= sync2;
      edge_q  <= sync2 & ~sync2_d;
    end
  end

  assign start_e = edge_q[0];
  assign lap_e   = edge_q[1];
  assign clear_e = edge_q[2];

  // Digit nibbles, LSB first: cs ones, cs tens, sec ones, sec tens, min ones, min tens.
  state_t        state, state_nx;
  logic [PW-1:0] presc;
  logic [23:0]   live, latch, up_val, dn_val, preset_cl, disp;
  logic          mode_q, lap_q, wrap_q, up_wrap, dn_zero, preset_zero;
  logic          tick, load_go, do_clear;
  logic [41:0]   seg_q;

  assign tick        = (state == RUN) && (presc == PMAX);
  assign load_go     = (state == IDLE) && start_e && !clear_e;
  assign do_clear    = clear_e && (state != RUN);
  assign preset_cl   = {clamp(bus.preset_min[7:4], 4'd9), clamp(bus.preset_min[3:0], 4'd9),
                        clamp(bus.preset_sec[7:4], 4'd5), clamp(bus.preset_sec[3:0], 4'd9), 8'h00};
  assign preset_zero = (preset_cl == 24'd0);
  assign dn_zero     = (dn_val == 24'd0);

  always_comb begin
    up_val  = live;
    up_wrap = 1'b0;
    if (live[3:0] != 4'd9) up_val[3:0] = live[3:0] + 4'd1;
    else begin
      up_val[3:0] = 4'd0;
      if (live[7:4] != 4'd9) up_val[7:4] = live[7:4] + 4'd1;
      else begin
        up_val[7:4] = 4'd0;
        if (live[11:8] != 4'd9) up_val[11:8] = live[11:8] + 4'd1;
        else begin
          up_val[11:8] = 4'd0;
          if (live[15:12] != 4'd5) up_val[15:12] = live[15:12] + 4'd1;
          else begin
            up_val[15:12] = 4'd0;
            if (live[23:20] == MAX_M1 && live[19:16] == MAX_M0) begin
              up_val[23:16] = 8'h00;
              up_wrap       = 1'b1;
            end else if (live[19:16] != 4'd9) up_val[19:16] = live[19:16] + 4'd1;
            else begin
              up_val[19:16] = 4'd0;
              up_val[23:20] = live[23:20] + 4'd1;
            end
          end
        end
      end
    end
  end

  // Borrow chain; never evaluated from 00:00.00 because that value leaves RUN.
  always_comb begin
    dn_val = live;
    if (live[3:0] != 4'd0) dn_val[3:0] = live[3:0] - 4'd1;
    else begin
      dn_val[3:0] = 4'd9;
      if (live[7:4] != 4'd0) dn_val[7:4] = live[7:4] - 4'd1;
      else begin
        dn_val[7:4] = 4'd9;
        if (live[11:8] != 4'd0) dn_val[11:8] = live[11:8] - 4'd1;
        else begin
          dn_val[11:8] = 4'd9;
          if (live[15:12] != 4'd0) dn_val[15:12] = live[15:12] - 4'd1;
          else begin
            dn_val[15:12] = 4'd5;
            if (live[19:16] != 4'd0) dn_val[19:16] = live[19:16] - 4'd1;
            else begin
              dn_val[19:16] = 4'd9;
              dn_val[23:20] = live[23:20] - 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Reaching zero in down mode outranks a same-cycle pause so the count never underflows.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (load_go) state_nx = (bus.mode_down && preset_zero) ? DONE : RUN;
      RUN: begin
        if (tick && mode_q && dn_zero) state_nx = DONE;
        else if (start_e)              state_nx = PAUSE;
      end
      PAUSE: begin
        if (clear_e)      state_nx = IDLE;
        else if (start_e) state_nx = RUN;
      end
      DONE:  if (clear_e) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.running   = (state == RUN);
    bus.done      = (state == DONE);
    bus.state_dbg = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      live   <= '0;
      latch  <= '0;
      mode_q <= 1'b0;
      lap_q  <= 1'b0;
      wrap_q <= 1'b0;
      seg_q  <= {6{SEG_ZERO}};
    end else begin
      wrap_q <= tick && !mode_q && up_wrap;
      if (load_go || do_clear) presc <= '0;
      else if (state == RUN)   presc <= tick ? '0 : presc + PW'(1);

      if (load_go) mode_q <= bus.mode_down;

      if (do_clear)     live <= '0;
      else if (load_go) live <= bus.mode_down ? preset_cl : 24'd0;
      else if (tick)    live <= mode_q ? dn_val : up_val;

      if (do_clear) lap_q <= 1'b0;
      else if (lap_e && (state == RUN || state == PAUSE)) begin
        lap_q <= !lap_q;
        if (!lap_q) latch <= live;
      end

      seg_q <= {seg_enc(disp[23:20]), seg_enc(disp[19:16]), seg_enc(disp[15:12]),
                seg_enc(disp[11:8]), seg_enc(disp[7:4]), seg_enc(disp[3:0])};
    end
  end

  assign disp           = lap_q ? latch : live;
  assign bus.lap_active = lap_q;
  assign bus.wrap       = wrap_q;
  assign bus.seg0       = seg_q[6:0];
  assign bus.seg1       = seg_q[13:7];
  assign bus.seg2       = seg_q[20:14];
  assign bus.seg3       = seg_q[27:21];
  assign bus.seg4       = seg_q[34:28];
  assign bus.seg5       = seg_q[41:35];

endmodule

// File: tb/tb_chrono_lap_timer.sv
// Bench for chrono_lap_timer: dut0 at DIV=10 (active-low segments), dut1 at DIV=2 (active-high)
// for the minute-rollover case. Times below are in hundredths; R = clocks spent in RUN.
module tb_chrono_lap_timer;

  logic clk;
  logic rst;
  int   n_pass   = 0;
  int   n_checks = 0;
  logic [44:0] exp_q[$];

  chrono_lap_timer_if bus0 ();
  chrono_lap_timer_if bus1 ();

  chrono_lap_timer #(.CLK_HZ(1000), .TICK_HZ(100), .MAX_MIN(1), .SEG_ACTIVE_LOW(1))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  chrono_lap_timer #(.CLK_HZ(200), .TICK_HZ(100), .MAX_MIN(1), .SEG_ACTIVE_LOW(0))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_pat(input int d, input bit al);
    logic [6:0] r;
    case (d)
      0: r = 7'b0111111;
      1: r = 7'b0000110;
      2: r = 7'b1011011;
      3: r = 7'b1001111;
      4: r = 7'b1100110;
      5: r = 7'b1101101;
      6: r = 7'b1111101;
      7: r = 7'b0000111;
      8: r = 7'b1111111;
      9: r = 7'b1101111;
      default: r = 7'b0000000;
    endcase
    return al ? ~r : r;
  endfunction

  // t in hundredths -> {seg5..seg0}
  function automatic logic [41:0] exp_segs(input int t, input bit al);
    int d[6];
    int m, s;
    logic [41:0] r;
    m = t / 6000;
    s = (t / 100) % 60;
    d[0] = t % 10;
    d[1] = (t / 10) % 10;
    d[2] = s % 10;
    d[3] = s / 10;
    d[4] = m % 10;
    d[5] = m / 10;
    for (int i = 0; i < 6; i++) r[i*7 +: 7] = seg_pat(d[i], al);
    return r;
  endfunction

  // flags: dut0 {running, done, lap_active}; dut1 {running, done, wrap}
  task automatic check(input int dut, input string name, input int t, input logic [2:0] flags);
    logic [44:0] e, got;
    exp_q.push_back({exp_segs(t, dut == 0), flags});
    if (dut == 0)
      got = {bus0.seg5, bus0.seg4, bus0.seg3, bus0.seg2, bus0.seg1, bus0.seg0,
             bus0.running, bus0.done, bus0.lap_active};
    else
      got = {bus1.seg5, bus1.seg4, bus1.seg3, bus1.seg2, bus1.seg1, bus1.seg0,
             bus1.running, bus1.done, bus1.wrap};
    e = exp_q.pop_front();
    n_checks++;
    if (got[44:3] === e[44:3]) n_pass++;
    else $display("FAIL %s segs: got %h want %h (t=%0d)", name, got[44:3], e[44:3], t);
    n_checks++;
    if (got[2:0] === e[2:0]) n_pass++;
    else $display("FAIL %s flags: got %b want %b", name, got[2:0], e[2:0]);
  endtask

  task automatic set_pins(input int dut, input bit s, input bit l, input bit c);
    if (dut == 0) begin
      bus0.start_stop = s; bus0.lap = l; bus0.clear = c;
    end else begin
      bus1.start_stop = s; bus1.lap = l; bus1.clear = c;
    end
  endtask

  // Called at a negedge; returns at the negedge after the edge has acted (4th posedge), plus hold.
  task automatic press(input int dut, input bit s, input bit l, input bit c, input int hold);
    set_pins(dut, s, l, c);
    repeat (4) @(posedge clk);
    @(negedge clk);
    repeat (hold) @(negedge clk);
    set_pins(dut, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam int A_START = 1, A_LAP = 2, A_CLEAR = 3, A_BOTH = 4;

  typedef struct {
    int         act;
    int         wt;
    int         t;
    logic [2:0] flags;
    string      name;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // Display after a wait shows floor((R-1)/10) while running, floor(R/10) once paused.
    vecs[0]  = '{A_START, 371, 37,  3'b100, "run_37"};       // R=371
    vecs[1]  = '{A_START, 500, 37,  3'b000, "pause_hold"};   // R=375 frozen
    vecs[2]  = '{A_START, 630, 100, 3'b100, "resume_100"};   // R=1005
    vecs[3]  = '{A_CLEAR, 20,  102, 3'b100, "clear_in_run"}; // ignored, R=1029
    vecs[4]  = '{A_START, 1,   103, 3'b000, "pause_103"};    // R=1033
    vecs[5]  = '{A_CLEAR, 1,   0,   3'b000, "clear_pause"};
    vecs[6]  = '{A_START, 502, 50,  3'b100, "run_50"};       // R=502
    vecs[7]  = '{A_LAP,   695, 50,  3'b101, "lap_freeze"};   // captured at R=506, now R=1201
    vecs[8]  = '{A_LAP,   1,   120, 3'b100, "lap_release"};  // toggled at R=1205
    vecs[9]  = '{A_BOTH,  1,   121, 3'b000, "both_in_run"};  // start wins, R=1210
    vecs[10] = '{A_BOTH,  1,   0,   3'b000, "both_in_pause"};// clear wins

    rst = 1'b1;
    bus0.start_stop = 0; bus0.lap = 0; bus0.clear = 0; bus0.mode_down = 0;
    bus0.preset_min = 8'h00; bus0.preset_sec = 8'h00;
    bus1.start_stop = 0; bus1.lap = 0; bus1.clear = 0; bus1.mode_down = 0;
    bus1.preset_min = 8'h00; bus1.preset_sec = 8'h00;
    wait_cyc(3);
    rst = 1'b0;
    check(0, "reset0", 0, 3'b000);
    check(1, "reset1", 0, 3'b000);

    // Held start button must give one pulse: held 34 clocks, still running.
    press(0, 1, 0, 0, 30);          // R=30
    wait_cyc(971);                  // R=1001
    check(0, "up_1s", 100, 3'b100);
    rst = 1'b1;
    #1;
    check(0, "rst_mid", 0, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      case (vecs[i].act)
        A_START: press(0, 1, 0, 0, 0);
        A_LAP:   press(0, 0, 1, 0, 0);
        A_CLEAR: press(0, 0, 0, 1, 0);
        default: press(0, 1, 0, 1, 0);
      endcase
      wait_cyc(vecs[i].wt);
      check(0, vecs[i].name, vecs[i].t, vecs[i].flags);
    end

    // Mode is sampled only at start: flipping it mid-run keeps counting up.
    press(0, 1, 0, 0, 0);
    bus0.mode_down = 1'b1;
    wait_cyc(100);                  // R=100
    check(0, "mode_latched", 9, 3'b100);
    press(0, 1, 0, 0, 0);
    wait_cyc(2);
    press(0, 0, 0, 1, 0);
    wait_cyc(1);
    check(0, "mode_clr", 0, 3'b000);

    // Countdown from 00:02.00: ticks at R=10n, zero reached at R=2000.
    bus0.preset_min = 8'h00;
    bus0.preset_sec = 8'h02;
    press(0, 1, 0, 0, 0);
    wait_cyc(1);
    check(0, "dn_load", 200, 3'b100);
    wait_cyc(1998);                 // R=1999
    check(0, "dn_last", 1, 3'b100);
    wait_cyc(2);
    check(0, "dn_done", 0, 3'b010);
    wait_cyc(50);
    check(0, "dn_hold", 0, 3'b010);
    press(0, 1, 0, 0, 0);
    wait_cyc(5);
    check(0, "done_start_ign", 0, 3'b010);
    press(0, 0, 0, 1, 0);
    wait_cyc(1);
    check(0, "done_clear", 0, 3'b000);

    // Zero preset: DONE right at the clock the start edge acts.
    bus0.preset_sec = 8'h00;
    bus0.start_stop = 1'b1;
    wait_cyc(3);
    check(0, "zero_pre", 0, 3'b000);
    wait_cyc(1);
    check(0, "zero_done", 0, 3'b010);
    bus0.start_stop = 1'b0;
    wait_cyc(3);
    press(0, 0, 0, 1, 0);
    wait_cyc(1);
    check(0, "zero_clr", 0, 3'b000);

    // Out-of-range preset clamps to 99:59.00.
    bus0.preset_min = 8'hAF;
    bus0.preset_sec = 8'h7C;
    press(0, 1, 0, 0, 0);
    wait_cyc(1);
    check(0, "clamp", 599900, 3'b100);
    press(0, 1, 0, 0, 0);
    wait_cyc(2);
    press(0, 0, 0, 1, 0);
    wait_cyc(1);
    check(0, "clamp_clr", 0, 3'b000);

    // dut1 (DIV=2, MAX_MIN=1): ticks = floor(R/2); tick 12000 at R=24000 rolls over.
    press(1, 1, 0, 0, 0);
    wait_cyc(23999);
    check(1, "pre_wrap", 11999, 3'b100);
    wait_cyc(1);
    check(1, "wrap_pulse", 11999, 3'b101);
    wait_cyc(1);
    check(1, "post_wrap", 0, 3'b100);
    wait_cyc(20);
    check(1, "wrap_cont", 10, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
